cmd_fifo_arbiter: RTL and testbench

CMD_FIFO_ARBITER -- requirements
Module: cmd_fifo_arbiter

---
 rtl/cmd_fifo_arbiter.sv | 138 +++++++++++++
 tb/tb_cmd_fifo_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_fifo_arbiter.sv
// cmd_fifo_arbiter
// Round-robin arbiter that forwards atomic multi-word commands from several
// requesters into a single engine command FIFO. A requester keeps the grant
// for all WORDS_PER_CMD words of its command, so commands never interleave.
// New grants need FIFO headroom (almost-full clear). Once a command has
// started, only FIFO full can stall it.

module cmd_fifo_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int WORDS_PER_CMD = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    input  logic [NUM_REQ*32-1:0] i_req_data,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  logic [NUM_REQ-1:0]    i_req_enable,
    output logic [31:0]           o_fifo_wdata,
    output logic                  o_fifo_wen,
    input  logic                  i_fifo_full,
    input  logic                  i_fifo_afull,
    output logic [2:0]            o_grant_id,
    output logic                  o_busy,
    output logic [31:0]           o_cmd_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    localparam logic [3:0] LAST_WORD  = 4'(WORDS_PER_CMD - 1);
    localparam logic [2:0] LAST_REQ_R = 3'(NUM_REQ - 1);

    logic [0:0]         state_r;
    logic [3:0]         word_cnt_r;
    logic [2:0]         last_grant_r;
    logic [2:0]         grant_r;
    logic [31:0]        cmd_count_r;

    logic [NUM_REQ-1:0] eligible_s;
    logic               found_s;
    logic [2:0]         pick_s;
    logic               can_grant_s;
    logic [NUM_REQ-1:0] ready_s;
    logic               grant_valid_s;
    logic [31:0]        grant_data_s;
    logic               push_s;
    logic               last_word_s;

    assign eligible_s = i_req_valid & i_req_enable;

    // Round-robin pick: first eligible index above last_grant, otherwise wrap to the lowest eligible index
    always_comb begin
        found_s = 1'b0;
        pick_s  = last_grant_r;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_s && eligible_s[k] && (3'(k) > last_grant_r)) begin
                found_s = 1'b1;
                pick_s  = 3'(k);
            end else begin
                found_s = found_s;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_s && eligible_s[k]) begin
                found_s = 1'b1;
                pick_s  = 3'(k);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign can_grant_s = (state_r == ST_IDLE) && found_s && !i_fifo_afull && !i_fifo_full;

    // Handshake for the held grant: only the granted requester sees ready, and only when the FIFO has room
    always_comb begin
        ready_s       = '0;
        grant_valid_s = 1'b0;
        grant_data_s  = 32'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_r == 3'(k)) begin
                ready_s[k]    = (state_r == ST_XFER) && !i_fifo_full;
                grant_valid_s = i_req_valid[k];
                grant_data_s  = i_req_data[32*k +: 32];
            end else begin
                ready_s[k] = 1'b0;
            end
        end
    end

    assign push_s      = grant_valid_s && (|ready_s);
    assign last_word_s = (word_cnt_r == LAST_WORD);

    // Arbitration / transfer state, word counter, grant history and completed-command counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r      <= ST_IDLE;
            word_cnt_r   <= 4'd0;
            last_grant_r <= LAST_REQ_R;
            grant_r      <= 3'd0;
            cmd_count_r  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (can_grant_s) begin
                        state_r    <= ST_XFER;
                        grant_r    <= pick_s;
                        word_cnt_r <= 4'd0;
                    end
                end
                ST_XFER: begin
                    if (push_s) begin
                        if (last_word_s) begin
                            state_r      <= ST_IDLE;
                            word_cnt_r   <= 4'd0;
                            last_grant_r <= grant_r;
                            cmd_count_r  <= cmd_count_r + 32'd1;
                        end else begin
                            word_cnt_r <= word_cnt_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    word_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    assign o_req_ready  = ready_s;
    assign o_fifo_wen   = push_s;
    assign o_fifo_wdata = push_s ? grant_data_s : 32'd0;
    assign o_grant_id   = grant_r;
    assign o_busy       = (state_r == ST_XFER);
    assign o_cmd_count  = cmd_count_r;

endmodule

// File: tb/tb_cmd_fifo_arbiter.sv
// Bench for cmd_fifo_arbiter. A transaction-level reference model (who owns
// the FIFO, how many words it has sent, who went last, and how many commands
// completed) predicts every output on every cycle. Directed steps come first,
// followed by a randomized phase.

module tb_cmd_fifo_arbiter;

    localparam int NR = 2;
    localparam int W  = 4;

    logic               i_clk;
    logic               i_reset_n;
    logic [NR-1:0]      valid;
    logic [NR-1:0]      en;
    logic               full;
    logic               afull;
    logic [31:0]        word [NR];
    logic [NR*32-1:0]   req_data;
    logic [NR-1:0]      o_req_ready;
    logic [31:0]        o_fifo_wdata;
    logic               o_fifo_wen;
    logic [2:0]         o_grant_id;
    logic               o_busy;
    logic [31:0]        o_cmd_count;

    assign req_data = {word[1], word[0]};

    cmd_fifo_arbiter #(.NUM_REQ(NR), .WORDS_PER_CMD(W)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_req_valid  (valid),
        .i_req_data   (req_data),
        .o_req_ready  (o_req_ready),
        .i_req_enable (en),
        .o_fifo_wdata (o_fifo_wdata),
        .o_fifo_wen   (o_fifo_wen),
        .i_fifo_full  (full),
        .i_fifo_afull (afull),
        .o_grant_id   (o_grant_id),
        .o_busy       (o_busy),
        .o_cmd_count  (o_cmd_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model
    bit          m_busy;
    int          m_grant;
    int          m_last;
    int          m_words;
    logic [31:0] m_count;

    // stimulus source and observation
    bit          auto_data;
    logic [31:0] base [NR];
    int          widx [NR];
    logic [31:0] pushed [$];
    logic [31:0] exp_q [$];
    int          busy_cyc;
    logic        obs_wen;
    logic        obs_busy;
    logic [2:0]  obs_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_grant = 0;
        m_last  = NR - 1;
        m_words = 0;
        m_count = 32'd0;
    endtask

    task automatic model_clock();
        bit found;
        found = 1'b0;
        if (!m_busy) begin
            for (int i = 1; i <= NR; i++) begin
                int k;
                k = (m_last + i) % NR;
                if (!found && valid[k] && en[k] && !afull && !full) begin
                    found   = 1'b1;
                    m_busy  = 1'b1;
                    m_grant = k;
                    m_words = 0;
                end
            end
        end else if (valid[m_grant] && !full) begin
            m_words++;
            if (m_words == W) begin
                m_busy  = 1'b0;
                m_words = 0;
                m_last  = m_grant;
                m_count = m_count + 32'd1;
            end
        end
    endtask

    // One clock cycle: entered and left at a falling edge with inputs already driven
    task automatic step();
        logic [NR-1:0] e_ready;
        logic          e_wen;
        logic [31:0]   e_wdata;
        if (!i_reset_n) model_reset();
        if (auto_data) begin
            for (int k = 0; k < NR; k++) word[k] = base[k] + 32'(widx[k]);
        end
        #1;
        e_ready = '0;
        e_wen   = 1'b0;
        e_wdata = 32'd0;
        if (m_busy && !full) begin
            e_ready[m_grant] = 1'b1;
            e_wen            = valid[m_grant];
            e_wdata          = e_wen ? word[m_grant] : 32'd0;
        end
        chk("ready", 32'(o_req_ready), 32'(e_ready));
        chk("wen",   32'(o_fifo_wen),  32'(e_wen));
        chk("wdata", o_fifo_wdata,     e_wdata);
        chk("busy",  32'(o_busy),      32'(m_busy));
        chk("grant", 32'(o_grant_id),  32'(m_grant));
        chk("count", o_cmd_count,      m_count);
        obs_wen   = o_fifo_wen;
        obs_busy  = o_busy;
        obs_grant = o_grant_id;
        if (o_busy) busy_cyc++;
        if (o_fifo_wen) pushed.push_back(o_fifo_wdata);
        for (int k = 0; k < NR; k++) begin
            if (valid[k] && o_req_ready[k]) widx[k]++;
        end
        @(posedge i_clk);
        if (i_reset_n) model_clock();
        @(negedge i_clk);
    endtask

    task automatic clear();
        pushed.delete();
        exp_q.delete();
        busy_cyc = 0;
        for (int k = 0; k < NR; k++) widx[k] = 0;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        step();
        i_reset_n = 1'b1;
    endtask

    task automatic check_pushed(input string tag);
        chk({tag, "_len"}, 32'(pushed.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < pushed.size()) chk({tag, "_word"}, pushed[i], exp_q[i]);
        end
    endtask

    initial begin
        i_reset_n = 1'b0;
        valid     = '0;
        en        = 2'b11;
        full      = 1'b0;
        afull     = 1'b0;
        auto_data = 1'b1;
        base[0]   = 32'h0000_00A0;
        base[1]   = 32'h0000_00B0;
        word[0]   = 32'd0;
        word[1]   = 32'd0;
        model_reset();
        clear();
        @(negedge i_clk);

        // reset state, with a requester already valid
        valid = 2'b01;
        step();
        chk("rst_busy",  32'(obs_busy),  32'd0);
        chk("rst_grant", 32'(obs_grant), 32'd0);
        chk("rst_wen",   32'(obs_wen),   32'd0);
        valid = '0;
        i_reset_n = 1'b1;
        step();

        // single command from requester 0
        clear();
        valid = 2'b01;
        step();
        chk("single_arb_nopush", 32'(obs_wen), 32'd0);
        repeat (4) step();
        valid = '0;
        step();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_00A0 + 32'(i));
        check_pushed("single");
        chk("single_count", o_cmd_count, 32'd1);
        chk("single_busy_cycles", 32'(busy_cyc), 32'd4);

        // contention: commands alternate 0,1,0,1 without interleaving
        do_reset();
        clear();
        valid = 2'b11;
        repeat (20) step();
        valid = '0;
        step();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back(((c % 2) == 0 ? 32'h0000_00A0 : 32'h0000_00B0) + 32'((c / 2) * 4 + i));
            end
        end
        check_pushed("contend");
        chk("contend_count", o_cmd_count, 32'd4);

        // backpressure after the second word
        do_reset();
        clear();
        valid = 2'b01;
        repeat (3) step();
        full = 1'b1;
        repeat (3) begin
            step();
            chk("bp_wen",   32'(obs_wen),   32'd0);
            chk("bp_busy",  32'(obs_busy),  32'd1);
            chk("bp_grant", 32'(obs_grant), 32'd0);
        end
        full = 1'b0;
        repeat (2) step();
        valid = '0;
        step();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_00A0 + 32'(i));
        check_pushed("bp");

        // almost-full blocks new grants only
        do_reset();
        clear();
        afull = 1'b1;
        valid = 2'b01;
        repeat (3) begin
            step();
            chk("afull_idle", 32'(obs_busy), 32'd0);
        end
        afull = 1'b0;
        step();
        chk("afull_arb", 32'(obs_busy), 32'd0);
        afull = 1'b1;
        step();
        chk("afull_granted", 32'(obs_busy), 32'd1);
        repeat (3) step();
        afull = 1'b0;
        valid = '0;
        step();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_00A0 + 32'(i));
        check_pushed("afull");
        chk("afull_count", o_cmd_count, 32'd1);

        // reset in the middle of a command
        clear();
        valid = 2'b01;
        repeat (3) step();
        i_reset_n = 1'b0;
        #1;
        chk("rstmid_wen",   32'(o_fifo_wen),  32'd0);
        chk("rstmid_ready", 32'(o_req_ready), 32'd0);
        chk("rstmid_count", o_cmd_count,      32'd0);
        chk("rstmid_busy",  32'(o_busy),      32'd0);
        step();
        i_reset_n = 1'b1;
        valid = 2'b11;
        step();
        step();
        chk("rstmid_first_grant", 32'(obs_grant), 32'd0);
        repeat (3) step();
        valid = '0;
        step();

        // enable mask excludes requester 0
        do_reset();
        clear();
        en    = 2'b10;
        valid = 2'b11;
        repeat (10) step();
        valid = '0;
        step();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h0000_00B0 + 32'(i));
        check_pushed("mask");
        chk("mask_count", o_cmd_count, 32'd2);
        en = 2'b11;

        // command counter wrap from a preloaded value
        clear();
        dut.cmd_count_r = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        valid = 2'b01;
        repeat (5) step();
        valid = '0;
        step();
        chk("wrap_count", o_cmd_count, 32'd0);

        // randomized traffic
        auto_data = 1'b0;
        for (int n = 0; n < 800; n++) begin
            valid     = 2'($urandom);
            en        = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            full      = ($urandom_range(0, 3) == 0);
            afull     = ($urandom_range(0, 2) == 0);
            i_reset_n = ($urandom_range(0, 99) != 0);
            word[0]   = $urandom;
            word[1]   = $urandom;
            step();
        end
        i_reset_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
